mag_power_ctrl: RTL and testbench
=================================

# mag_power_ctrl

Parametrised magnetron controller for the microwave oven's magnetron-control path. It replaces the purely combinational start/stop/clear/door/timer decoder with a registered cook state machine that adds pause/resume and duty-cycle power levels. Its outputs are `mag_on` plus one-cycle `S`/`R` edge pulses, which drive the existing magnetron latch.

## Interface
- `CYCLE_LEN`, default 10: ticks per power frame; must be ≥ 2.
- `PWR_W`, default 4: width of `power_level`; must satisfy 2^PWR_W − 1 ≥ `CYCLE_LEN`.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `startn` in 1: start request, active-low, level-sampled each clock.
- `stopn` in 1: stop/pause request, active-low.
- `clrn` in 1: clear request, active-low.
- `door_closed` in 1: 1 = door closed.
- `timer_done` in 1: cook timer expired, level.
- `tick` in 1: one-cycle frame-time enable from the timebase.
- `power_level` in `PWR_W`: on-ticks per frame, in the range 0..`CYCLE_LEN`.
- `state` out 2: IDLE=0, COOK=1, PAUSE=2, DONE=3.
- `mag_on` out 1: magnetron enable.
- `S` out 1: one-cycle pulse when `mag_on` rises.
- `R` out 1: one-cycle pulse when `mag_on` falls.
- `done` out 1: high while in DONE.

## Operation
- Reset (`rst`=1 at an edge) sets the following registered values:
  - `state`=IDLE, frame counter `cnt`=0, latched duty `duty_q`=0, `mag_on_d`=0.
  - Resulting outputs: `mag_on`=0, `S`=0, `R`=0, `done`=0.
  - `rst` has priority over everything, including mid-cook.
- Input priority is clrn > door open > timer_done > stopn > startn. Only the highest-priority active condition acts in a given cycle.
- Start condition: `startn`=0 && `door_closed`=1 && `timer_done`=0.
- IDLE transitions:
  - Start condition → COOK; `cnt`←0; `duty_q`←min(`power_level`, `CYCLE_LEN`).
  - Otherwise stay in IDLE.
- COOK transitions:
  - `clrn`=0 → IDLE.
  - `door_closed`=0 → PAUSE.
  - `timer_done`=1 → DONE.
  - `stopn`=0 → PAUSE.
  - Otherwise stay in COOK.
  - `startn` has no effect while in COOK.
- PAUSE transitions:
  - `clrn`=0 → IDLE.
  - `timer_done`=1 → DONE.
  - Start condition → COOK. `cnt` and `duty_q` are kept; `power_level` is not resampled.
- DONE transitions:
  - `clrn`=0 or `door_closed`=0 → IDLE.
  - `startn` is ignored; a fresh start requires passing through IDLE.
- Frame counter:
  - In COOK with `tick`=1: `cnt`←`cnt`+1, wrapping `CYCLE_LEN`−1 → 0.
  - Frozen in PAUSE and DONE.
  - Cleared in IDLE.
  - Width is $clog2(`CYCLE_LEN`).
- `mag_on` = (`state`==COOK) && (`cnt` < `duty_q`) && `door_closed`.
  - It is decoded from flops, with `door_closed` gated combinationally. This gating is a safety requirement.
  - `duty_q`=0 → `mag_on` never asserts.
  - `duty_q`=`CYCLE_LEN` → `mag_on` is continuously on.
- Edge pulses, with `mag_on_d` = `mag_on` registered:
  - `S` = `mag_on` & ~`mag_on_d`.
  - `R` = ~`mag_on` & `mag_on_d`.

## Timing
- Control inputs sampled at edge k change `state` after edge k; `mag_on` follows in the same cycle. This gives 1-cycle latency from request to `mag_on`.
- Door opening drops `mag_on` with 0-cycle (combinational) latency. `state` reaches PAUSE after the next edge.
- `S`/`R` are high exactly in the first cycle of the new `mag_on` level. They are never both high in the same cycle.
- `tick` in the same cycle as a COOK exit: the counter does not advance.
- `tick` coinciding with entry to COOK: the counter starts at 0; that tick is not counted.
- `power_level` > `CYCLE_LEN` saturates to `CYCLE_LEN`.

## Structure
- `mag_pkg` holds:
  - the state enum (IDLE/COOK/PAUSE/DONE) and its 2-bit encoding;
  - the input-priority ordering.
- One sub-module, `mag_frame_counter`: the wrapping tick counter with clear/enable, parametrised by `CYCLE_LEN`.
- The top level holds the FSM, duty latch, `mag_on` decode and the `S`/`R` edge detect.

## Test plan
All cases use `CYCLE_LEN`=10.
- **Start and modulation:** reset, then `startn`=0 for one cycle with `power_level`=3 and door closed.
  - `state`=COOK next cycle.
  - `mag_on` high for ticks 0–2, low for 3–9, repeating.
  - `S` pulses at each on-edge; `R` pulses at each off-edge.
- **Door open mid-cook:** open the door while `mag_on`=1 at `cnt`=1.
  - `mag_on`=0 in the same cycle; `R` pulses; `state`=PAUSE next.
- **Resume:** close the door, then `startn`=0.
  - COOK resumes with `cnt`=1 and `duty_q`=3 unchanged.
- **Simultaneous requests:** in COOK, drive `clrn`=0, `stopn`=0 and `timer_done`=1 together.
  - `state`=IDLE; `cnt`=0.
- **DONE handling:** `timer_done`=1 in COOK → DONE.
  - `done`=1 and `mag_on`=0.
  - `startn`=0 is ignored.
  - Door open → IDLE.
- **Power boundaries:**
  - `power_level`=0 → `mag_on` never asserts.
  - `power_level`=15 → saturates; `mag_on` is continuously on.
  - `rst` asserted mid-cook → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/mag_pkg.sv
// Shared types for the magnetron controller: cook states and request priority.
package mag_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Highest-priority active request in a cycle; only that one acts.
  typedef enum logic [2:0] {
    REQ_CLR,
    REQ_DOOR,
    REQ_TIMER,
    REQ_STOP,
    REQ_START,
    REQ_NONE
  } req_e;

  // clrn > door open > timer_done > stopn > startn
  function automatic req_e decode_req(
    input logic clrn,
    input logic door_closed,
    input logic timer_done,
    input logic stopn,
    input logic startn
  );
    if (!clrn)             return REQ_CLR;
    else if (!door_closed) return REQ_DOOR;
    else if (timer_done)   return REQ_TIMER;
    else if (!stopn)       return REQ_STOP;
    else if (!startn)      return REQ_START;
    else                   return REQ_NONE;
  endfunction

endpackage

// File: rtl/mag_frame_counter.sv
// Wrapping power-frame tick counter with synchronous clear and count enable.
module mag_frame_counter #(
  parameter int unsigned CYCLE_LEN = 10,
  parameter int unsigned CNT_W     = $clog2(CYCLE_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise advance and wrap at CYCLE_LEN-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_W'(CYCLE_LEN - 1)) cnt_d = '0;
      else                                cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mag_power_ctrl.sv
// Cook state machine with pause/resume, duty-cycle power and S/R edge pulses.
module mag_power_ctrl
  import mag_pkg::*;
#(
  parameter int unsigned CYCLE_LEN = 10,
  parameter int unsigned PWR_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startn,
  input  logic             stopn,
  input  logic             clrn,
  input  logic             door_closed,
  input  logic             timer_done,
  input  logic             tick,
  input  logic [PWR_W-1:0] power_level,
  output logic [1:0]       state,
  output logic             mag_on,
  output logic             S,
  output logic             R,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(CYCLE_LEN);

  state_e           state_q, state_d;
  logic [PWR_W-1:0] duty_q, duty_d;
  logic             done_q, done_d;
  logic             mag_on_d_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr, cnt_en;
  req_e             req;

  // Next-state, duty latch and counter control from the prioritised request.
  always_comb begin
    req     = decode_req(clrn, door_closed, timer_done, stopn, startn);
    state_d = state_q;
    duty_d  = duty_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req == REQ_START) begin
          state_d = ST_COOK;
          duty_d  = (power_level > PWR_W'(CYCLE_LEN)) ? PWR_W'(CYCLE_LEN) : power_level;
        end
      end
      ST_COOK: begin
        case (req)
          REQ_CLR:   state_d = ST_IDLE;
          REQ_DOOR:  state_d = ST_PAUSE;
          REQ_TIMER: state_d = ST_DONE;
          REQ_STOP:  state_d = ST_PAUSE;
          default:   state_d = ST_COOK;
        endcase
      end
      ST_PAUSE: begin
        // Door open outranks timer_done, so an open door simply holds PAUSE.
        case (req)
          REQ_CLR:   state_d = ST_IDLE;
          REQ_TIMER: state_d = ST_DONE;
          REQ_START: state_d = ST_COOK;
          default:   state_d = ST_PAUSE;
        endcase
      end
      ST_DONE: begin
        if (!clrn || !door_closed) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    done_d  = (state_d == ST_DONE);
    // Clearing on the IDLE-bound transition keeps cnt at 0 for the whole IDLE stay;
    // ticks only count while staying in COOK, so entry/exit ticks are dropped.
    cnt_clr = (state_d == ST_IDLE);
    cnt_en  = tick && (state_q == ST_COOK) && (state_d == ST_COOK);
  end

  // FSM, duty, done and delayed mag_on registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      duty_q     <= '0;
      done_q     <= 1'b0;
      mag_on_d_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      done_q     <= done_d;
      mag_on_d_q <= mag_on;
    end
  end

  mag_frame_counter #(
    .CYCLE_LEN (CYCLE_LEN),
    .CNT_W     (CNT_W)
  ) u_frame_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt)
  );

  // door_closed is gated combinationally so an opening door kills RF immediately.
  assign mag_on = (state_q == ST_COOK) && (PWR_W'(cnt) < duty_q) && door_closed;
  assign S      = mag_on & ~mag_on_d_q;
  assign R      = ~mag_on & mag_on_d_q;
  assign state  = state_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mag_power_ctrl.sv
// Directed-vector bench for mag_power_ctrl with a queue-based scoreboard.
module tb_mag_power_ctrl;

  logic       clk = 1'b0;
  logic       rst, startn, stopn, clrn, door_closed, timer_done, tick;
  logic [3:0] power_level;
  logic [1:0] state;
  logic       mag_on, S, R, done;

  typedef struct packed {
    logic [1:0] st;
    logic       mag;
    logic       s;
    logic       r;
    logic       dn;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_idx = 0;

  always #5 clk = ~clk;

  mag_power_ctrl #(
    .CYCLE_LEN (10),
    .PWR_W     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .startn      (startn),
    .stopn       (stopn),
    .clrn        (clrn),
    .door_closed (door_closed),
    .timer_done  (timer_done),
    .tick        (tick),
    .power_level (power_level),
    .state       (state),
    .mag_on      (mag_on),
    .S           (S),
    .R           (R),
    .done        (done)
  );

  // Monitor: outputs are stable at the falling edge; pop one expectation per cycle.
  initial begin
    exp_t e;
    int   idx;
    idx = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({state, mag_on, S, R, done} !== e) begin
          n_bad++;
          $display("FAIL vec%0d: got state=%0d mag_on=%b S=%b R=%b done=%b, expected state=%0d mag_on=%b S=%b R=%b done=%b",
                   idx, state, mag_on, S, R, done, e.st, e.mag, e.s, e.r, e.dn);
        end
        idx++;
      end
    end
  end

  // Inputs currently set apply to this cycle; push the outputs expected before the next edge.
  task automatic cyc(input logic [1:0] st, input logic mag, input logic s,
                     input logic r, input logic dn);
    exp_t e;
    e.st = st; e.mag = mag; e.s = s; e.r = r; e.dn = dn;
    exp_q.push_back(e);
    vec_idx++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; startn = 1'b1; stopn = 1'b1; clrn = 1'b1;
    door_closed = 1'b1; timer_done = 1'b0; tick = 1'b0; power_level = 4'd3;
    @(posedge clk);
    #1;

    // Reset state
    cyc(2'd0, 0, 0, 0, 0);
    // Start at power 3
    rst = 1'b0; startn = 1'b0;
    cyc(2'd0, 0, 0, 0, 0);
    startn = 1'b1; tick = 1'b1;
    cyc(2'd1, 1, 1, 0, 0);                      // cnt0
    cyc(2'd1, 1, 0, 0, 0);                      // cnt1
    cyc(2'd1, 1, 0, 0, 0);                      // cnt2
    cyc(2'd1, 0, 0, 1, 0);                      // cnt3 off-edge
    for (int i = 4; i <= 9; i++) cyc(2'd1, 0, 0, 0, 0);
    cyc(2'd1, 1, 1, 0, 0);                      // cnt0 of second frame
    // Door opens at cnt1 with a coincident tick: immediate drop
    door_closed = 1'b0;
    cyc(2'd1, 0, 0, 1, 0);
    tick = 1'b0;
    cyc(2'd2, 0, 0, 0, 0);
    door_closed = 1'b1;
    cyc(2'd2, 0, 0, 0, 0);
    // Resume; new power_level must not be sampled, entry tick not counted
    startn = 1'b0; tick = 1'b1; power_level = 4'd9;
    cyc(2'd2, 0, 0, 0, 0);
    startn = 1'b1;
    cyc(2'd1, 1, 1, 0, 0);                      // cnt1
    startn = 1'b0;                              // ignored in COOK
    cyc(2'd1, 1, 0, 0, 0);                      // cnt2
    startn = 1'b1;
    cyc(2'd1, 0, 0, 1, 0);                      // cnt3
    // Simultaneous clear/stop/timer: clear wins
    clrn = 1'b0; stopn = 1'b0; timer_done = 1'b1;
    cyc(2'd1, 0, 0, 0, 0);
    clrn = 1'b1; stopn = 1'b1; timer_done = 1'b0; tick = 1'b0;
    cyc(2'd0, 0, 0, 0, 0);
    // Restart to confirm counter cleared to 0
    startn = 1'b0; power_level = 4'd3;
    cyc(2'd0, 0, 0, 0, 0);
    startn = 1'b1;
    cyc(2'd1, 1, 1, 0, 0);
    // Timer expiry -> DONE; start ignored; door open -> IDLE
    timer_done = 1'b1;
    cyc(2'd1, 1, 0, 0, 0);
    startn = 1'b0;
    cyc(2'd3, 0, 0, 1, 1);
    startn = 1'b1;
    cyc(2'd3, 0, 0, 0, 1);
    door_closed = 1'b0;
    cyc(2'd3, 0, 0, 0, 1);
    door_closed = 1'b1; timer_done = 1'b0;
    cyc(2'd0, 0, 0, 0, 0);
    // Power 0: never on
    startn = 1'b0; power_level = 4'd0;
    cyc(2'd0, 0, 0, 0, 0);
    startn = 1'b1; tick = 1'b1;
    for (int i = 0; i < 11; i++) cyc(2'd1, 0, 0, 0, 0);
    clrn = 1'b0;
    cyc(2'd1, 0, 0, 0, 0);
    // Power 15 saturates to 10: continuously on across wrap
    clrn = 1'b1; startn = 1'b0; power_level = 4'd15;
    cyc(2'd0, 0, 0, 0, 0);
    startn = 1'b1;
    cyc(2'd1, 1, 1, 0, 0);
    for (int i = 0; i < 11; i++) cyc(2'd1, 1, 0, 0, 0);
    // Reset mid-cook
    rst = 1'b1;
    cyc(2'd1, 1, 0, 0, 0);
    rst = 1'b0;
    cyc(2'd0, 0, 0, 0, 0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
